// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain / UART transmit slice.
// State encoding, data width and line levels used by the drain FSM.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_POP    = ST_POP,
        S_LOAD   = ST_LOAD,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } state_t;

    function automatic logic calc_parity(
        input logic [DATA_W-1:0] data,
        input logic              odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Held at zero while clr is high so the first bit starts a full period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_tick
);

    localparam int RAW_W = $clog2(CLKS_PER_BIT + 1);
    localparam int CW    = (RAW_W < 1) ? 1 : RAW_W;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_tick = !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame and shifts it out as 8N1/8E1/8O1
// with one or two stop bits on a registered, idle-high serial line.
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_nostock,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [CNT_W-1:0]  byte_cnt
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("fifo_uart_tx: CLKS_PER_BIT out of range");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end

    state_t            state;
    state_t            state_d;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_d;
    logic              par_bit;
    logic              par_d;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_d;
    logic              tx_q;
    logic              tx_d;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic              bit_tick;
    logic              baud_clr;
    logic              last_stop;
    logic              done_d;

    // Baud timer only runs while a bit is on the line.
    assign baud_clr  = (state == S_IDLE) || (state == S_POP) ||
                       (state == S_LOAD);
    assign last_stop = (bit_cnt == 3'(STOP_BITS - 1));

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (baud_clr),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d   = state;
        sreg_d    = sreg;
        par_d     = par_bit;
        bit_cnt_d = bit_cnt;
        done_d    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable && !fifo_nostock) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                sreg_d    = fifo_dout;
                par_d     = calc_parity(fifo_dout, PARITY_ODD != 0);
                bit_cnt_d = '0;
                state_d   = S_START;
            end
            S_START: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    sreg_d = sreg >> 1;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (last_stop) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so tx can be a flop.
    always_comb begin
        tx_d = LINE_IDLE;
        unique case (state_d)
            S_START:  tx_d = LINE_START;
            S_DATA:   tx_d = sreg_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sreg       <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            tx_q       <= LINE_IDLE;
            byte_cnt_q <= '0;
        end else begin
            state   <= state_d;
            sreg    <= sreg_d;
            par_bit <= par_d;
            bit_cnt <= bit_cnt_d;
            tx_q    <= tx_d;
            if (done_d) begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end
        end
    end

    assign fifo_rd  = (state == S_POP);
    assign busy     = (state != S_IDLE);
    assign tx_done  = done_d;
    assign tx       = tx_q;
    assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: four DUT variants (8N1, 8E1, 8O1, 8N2) fed by FIFO models,
// with per-channel monitors comparing every line cycle to the expected frame.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       en;
    logic [3:0]       wr_en;
    logic [3:0][7:0]  wr_data;
    logic [3:0]       tx_w;
    logic [3:0]       busy_w;
    logic [3:0]       done_w;
    logic [3:0]       rd_w;
    logic [3:0][15:0] cnt_w;
    logic [3:0]       in_fr;
    logic [3:0]       par_seen;

    int checks = 0;
    int errors = 0;
    int stray = 0;
    int cyc_now = 0;
    int rd_cyc[4] = '{default: 0};
    int start_cyc[4] = '{default: 0};
    int last_gap[4] = '{default: 0};
    int frames[4] = '{default: 0};
    int pops[4] = '{default: 0};

    always @(posedge clk) cyc_now <= cyc_now + 1;

    for (genvar g = 0; g < 4; g++) begin : ch
        localparam int PE = (g == 1 || g == 2) ? 1 : 0;
        localparam int PO = (g == 2) ? 1 : 0;
        localparam int SB = (g == 3) ? 2 : 1;
        localparam int FLEN = (1 + 8 + PE + SB) * CPB;

        logic [7:0] mem[16];
        int wp = 0;
        int rp = 0;
        logic [7:0] dout = '0;
        logic nostock;
        logic [7:0] exp_q[$];
        logic [11:0] bits;
        logic [7:0] cur;
        int cyc;
        int idle_run = 0;
        int bad_cyc;
        logic bad_got;
        logic bad_req;

        assign nostock = (wp == rp);

        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (en[g]),
            .fifo_nostock(nostock),
            .fifo_dout   (dout),
            .fifo_rd     (rd_w[g]),
            .tx          (tx_w[g]),
            .busy        (busy_w[g]),
            .tx_done     (done_w[g]),
            .byte_cnt    (cnt_w[g])
        );

        // FIFO model: registered read data, expected bytes queued on write
        always @(posedge clk) begin
            if (wr_en[g] === 1'b1) begin
                mem[wp % 16] <= wr_data[g];
                exp_q.push_back(wr_data[g]);
                wp <= wp + 1;
            end
            if (rd_w[g] === 1'b1) begin
                if (wp == rp) stray++;
                dout <= mem[rp % 16];
                rp <= rp + 1;
                pops[g]++;
                rd_cyc[g] = cyc_now;
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                in_fr[g] = 1'b0;
                idle_run = 0;
            end else begin
                if (!in_fr[g] && tx_w[g] === 1'b0) begin
                    last_gap[g] = idle_run;
                    start_cyc[g] = cyc_now;
                    in_fr[g] = 1'b1;
                    cyc = 0;
                    bad_cyc = -1;
                    bad_got = 1'b0;
                    bad_req = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL ch%0d unexpected_frame: got start bit, required no frame", g);
                        cur = 8'h00;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    bits = '1;
                    bits[0] = 1'b0;
                    bits[8:1] = cur;
                    if (PE != 0) bits[9] = (^cur) ^ (PO != 0);
                end
                if (in_fr[g]) begin
                    if (PE != 0 && cyc == 9 * CPB + CPB / 2) par_seen[g] = tx_w[g];
                    if (bad_cyc < 0 && tx_w[g] !== bits[cyc / CPB]) begin
                        bad_cyc = cyc;
                        bad_got = tx_w[g];
                        bad_req = bits[cyc / CPB];
                    end
                    if (bad_cyc < 0 && done_w[g] !== (cyc == FLEN - 1)) begin
                        bad_cyc = cyc;
                        bad_got = done_w[g];
                        bad_req = (cyc == FLEN - 1);
                    end
                    if (cyc == FLEN - 1) begin
                        checks++;
                        if (bad_cyc >= 0) begin
                            errors++;
                            $display("FAIL ch%0d frame_%02h: cycle %0d of %0d got tx/tx_done %b, required %b",
                                     g, cur, bad_cyc, FLEN, bad_got, bad_req);
                        end
                        frames[g]++;
                        in_fr[g] = 1'b0;
                        idle_run = 0;
                    end else begin
                        cyc++;
                    end
                end else begin
                    idle_run++;
                    if (done_w[g] === 1'b1) stray++;
                end
            end
        end
    end

    task automatic push(input int g, input logic [7:0] b);
        @(negedge clk);
        wr_en[g] = 1'b1;
        wr_data[g] = b;
        @(negedge clk);
        wr_en[g] = 1'b0;
    endtask

    task automatic wait_frames(input int g, input int n, input int budget);
        int k = 0;
        while (frames[g] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (frames[g] < n) begin
            errors++;
            $display("FAIL ch%0d wait_frames: got %0d frames, required %0d within %0d cycles",
                     g, frames[g], n, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input int g, input int budget);
        int k = 0;
        while (!in_fr[g] && k < budget) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (!in_fr[g]) begin
            errors++;
            $display("FAIL ch%0d wait_start: no start bit, required one within %0d cycles", g, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = '1;
        wr_en = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if ({tx_w[g], busy_w[g], done_w[g], rd_w[g], cnt_w[g]} !== {4'b1000, 16'h0}) begin
                errors++;
                $display("FAIL ch%0d reset_state: got tx/busy/done/rd=%b%b%b%b cnt=%0d, required 1000 cnt=0",
                         g, tx_w[g], busy_w[g], done_w[g], rd_w[g], cnt_w[g]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int f0 = frames[0];
        int p0 = pops[0];
        push(0, 8'hA5);
        wait_frames(0, f0 + 1, 200);
        checks++;
        if (pops[0] - p0 !== 1) begin
            errors++;
            $display("FAIL single_pops: got %0d, required 1", pops[0] - p0);
        end
        checks++;
        if (start_cyc[0] - rd_cyc[0] !== 2) begin
            errors++;
            $display("FAIL single_rd_to_start: got %0d, required 2", start_cyc[0] - rd_cyc[0]);
        end
        checks++;
        if (cnt_w[0] !== 16'd1) begin
            errors++;
            $display("FAIL single_byte_cnt: got %0d, required 1", cnt_w[0]);
        end
        checks++;
        if (busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %b, required 0", busy_w[0]);
        end
    endtask

    task automatic test_parity();
        push(1, 8'hA5);
        push(2, 8'hA5);
        wait_frames(1, 1, 200);
        wait_frames(2, 1, 200);
        checks++;
        if (par_seen[1] !== 1'b0) begin
            errors++;
            $display("FAIL even_parity_bit: got %b, required 0", par_seen[1]);
        end
        checks++;
        if (par_seen[2] !== 1'b1) begin
            errors++;
            $display("FAIL odd_parity_bit: got %b, required 1", par_seen[2]);
        end
        checks++;
        if (cnt_w[1] !== 16'd1 || cnt_w[2] !== 16'd1) begin
            errors++;
            $display("FAIL parity_byte_cnt: got %0d/%0d, required 1/1", cnt_w[1], cnt_w[2]);
        end
    endtask

    task automatic test_stop2();
        push(3, 8'hA5);
        push(3, 8'h0F);
        wait_frames(3, 2, 300);
        checks++;
        if (cnt_w[3] !== 16'd2) begin
            errors++;
            $display("FAIL stop2_byte_cnt: got %0d, required 2", cnt_w[3]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int f0 = frames[0];
        int p0;
        push(0, 8'h3C);
        wait_start(0, 50);
        repeat (16) @(posedge clk);
        #3;
        checks++;
        if (busy_w[0] !== 1'b1 || cnt_w[0] !== 16'd1) begin
            errors++;
            $display("FAIL mid_pre_reset: got busy=%b cnt=%0d, required busy=1 cnt=1", busy_w[0], cnt_w[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_w[0], busy_w[0], cnt_w[0]} !== {2'b10, 16'h0}) begin
            errors++;
            $display("FAIL mid_reset_state: got tx=%b busy=%b cnt=%0d, required tx=1 busy=0 cnt=0",
                     tx_w[0], busy_w[0], cnt_w[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = pops[0];
        repeat (10) @(negedge clk);
        checks++;
        if (pops[0] !== p0 || frames[0] !== f0) begin
            errors++;
            $display("FAIL mid_no_rerequest: got pops+%0d frames+%0d, required 0/0", pops[0] - p0, frames[0] - f0);
        end
        push(0, 8'hC3);
        wait_frames(0, f0 + 1, 200);
        checks++;
        if (cnt_w[0] !== 16'd1) begin
            errors++;
            $display("FAIL mid_restart_cnt: got %0d, required 1", cnt_w[0]);
        end
    endtask

    task automatic test_back_to_back();
        int f0 = frames[0];
        int p0 = pops[0];
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        wait_frames(0, f0 + 3, 600);
        checks++;
        if (last_gap[0] !== 3) begin
            errors++;
            $display("FAIL burst_gap: got %0d idle cycles, required 3", last_gap[0]);
        end
        checks++;
        if (cnt_w[0] !== 16'd4) begin
            errors++;
            $display("FAIL burst_byte_cnt: got %0d, required 4", cnt_w[0]);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (pops[0] - p0 !== 3 || busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL burst_drain: got pops=%0d busy=%b, required pops=3 busy=0", pops[0] - p0, busy_w[0]);
        end
    endtask

    task automatic test_enable_gating();
        int f0 = frames[0];
        int p0 = pops[0];
        int tx_high = 0;
        en[0] = 1'b0;
        push(0, 8'h77);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_w[0] === 1'b1) tx_high++;
        end
        checks++;
        if (pops[0] !== p0 || tx_high !== 50) begin
            errors++;
            $display("FAIL enable_hold: got pops+%0d tx_high=%0d, required 0 and 50", pops[0] - p0, tx_high);
        end
        en[0] = 1'b1;
        wait_start(0, 20);
        repeat (15) @(posedge clk);
        @(negedge clk);
        en[0] = 1'b0;
        push(0, 8'h88);
        wait_frames(0, f0 + 1, 200);
        repeat (30) @(negedge clk);
        checks++;
        if (pops[0] - p0 !== 1 || frames[0] !== f0 + 1 || busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop: got pops+%0d frames+%0d busy=%b, required 1/1/0",
                     pops[0] - p0, frames[0] - f0, busy_w[0]);
        end
        en[0] = 1'b1;
        wait_frames(0, f0 + 2, 200);
        checks++;
        if (cnt_w[0] !== 16'd6) begin
            errors++;
            $display("FAIL enable_byte_cnt: got %0d, required 6", cnt_w[0]);
        end
    endtask

    task automatic test_wrap();
        int f0 = frames[0];
        @(negedge clk);
        force ch[0].dut.byte_cnt_q = 16'hFFFF;
        @(negedge clk);
        release ch[0].dut.byte_cnt_q;
        @(negedge clk);
        checks++;
        if (cnt_w[0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preset: got %h, required ffff", cnt_w[0]);
        end
        push(0, 8'h5A);
        wait_frames(0, f0 + 1, 200);
        checks++;
        if (cnt_w[0] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_byte_cnt: got %h, required 0000", cnt_w[0]);
        end
    endtask

    task automatic test_leftovers();
        int left;
        left = ch[0].exp_q.size() + ch[1].exp_q.size() + ch[2].exp_q.size() + ch[3].exp_q.size();
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL stray_events: got %0d stray pops/tx_done pulses, required 0", stray);
        end
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL unsent_bytes: got %0d, required 0", left);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_parity();
        test_stop2();
        test_reset_mid_frame();
        test_back_to_back();
        test_enable_gating();
        test_wrap();
        test_leftovers();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
